// File: rtl/sad_pkg.sv
// Shared definitions for the SAD minimum search: search FSM encoding and width helpers.
package sad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic int sad_width(input int dwidth);
        return dwidth + 8;
    endfunction

    // Smallest signed width able to hold +/-range.
    function automatic int mv_min_width(input int range);
        return $clog2(range + 1) + 1;
    endfunction

endpackage

// File: rtl/sad_mv_raster_cnt.sv
// Signed x/y raster counter over [-RANGE, +RANGE]^2; x fastest. Flags the last candidate (+RANGE, +RANGE).
module sad_mv_raster_cnt #(
    parameter int RANGE = 4,
    parameter int MVW   = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    input  logic                  adv_i,
    output logic signed [MVW-1:0] x_o,
    output logic signed [MVW-1:0] y_o,
    output logic                  last_o
);

    localparam logic signed [MVW-1:0] MV_MAX = MVW'(RANGE);
    localparam logic signed [MVW-1:0] MV_MIN = -MV_MAX;

    logic signed [MVW-1:0] x_q;
    logic signed [MVW-1:0] y_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q <= MV_MIN;
            y_q <= MV_MIN;
        end else if (clr_i) begin
            x_q <= MV_MIN;
            y_q <= MV_MIN;
        end else if (adv_i) begin
            if (x_q == MV_MAX) begin
                x_q <= MV_MIN;
                // Wrapping y after the last candidate leaves the counter ready for the next search.
                y_q <= (y_q == MV_MAX) ? MV_MIN : y_q + MVW'(1);
            end else begin
                x_q <= x_q + MVW'(1);
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == MV_MAX) && (y_q == MV_MAX);

endmodule

// File: rtl/sad_min_search.sv
// Tracks the minimum SAD and its motion vector over a full +/-RANGE search window.
// Optional SAD_MIN_ZERO_BIAS_EN: the (0,0) candidate competes with a saturating ZERO_BIAS credit.
module sad_min_search
    import sad_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int RANGE     = 4,
    parameter int MVW       = 5,
    parameter int ZERO_BIAS = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DWIDTH+7:0]     sad,
    input  logic                  sad_vld,
    output logic signed [MVW-1:0] cand_mvx,
    output logic signed [MVW-1:0] cand_mvy,
    output logic                  busy,
    output logic                  done,
    output logic [DWIDTH+7:0]     best_sad,
    output logic signed [MVW-1:0] best_mvx,
    output logic signed [MVW-1:0] best_mvy,
    output logic                  err_stray
);

    localparam int SAD_W = sad_width(DWIDTH);

    state_e                state_q;
    logic                  done_q;
    logic                  err_stray_q;
    logic [SAD_W-1:0]      min_key_q;
    logic [SAD_W-1:0]      best_sad_q;
    logic signed [MVW-1:0] best_mvx_q;
    logic signed [MVW-1:0] best_mvy_q;

    logic signed [MVW-1:0] cnt_x;
    logic signed [MVW-1:0] cnt_y;
    logic                  cnt_last;
    logic                  cnt_clr;
    logic                  cnt_adv;
    logic [SAD_W-1:0]      key;

    assign cnt_clr = (state_q == ST_IDLE) && start;
    assign cnt_adv = (state_q == ST_SEARCH) && sad_vld;

    sad_mv_raster_cnt #(
        .RANGE (RANGE),
        .MVW   (MVW)
    ) u_raster (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (cnt_clr),
        .adv_i  (cnt_adv),
        .x_o    (cnt_x),
        .y_o    (cnt_y),
        .last_o (cnt_last)
    );

`ifdef SAD_MIN_ZERO_BIAS_EN
    localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS);

    always_comb begin
        key = sad;
        if (cnt_x == '0 && cnt_y == '0) begin
            key = (sad > BIAS) ? sad - BIAS : '0;
        end
    end
`else
    logic zero_bias_unused;
    assign zero_bias_unused = ^ZERO_BIAS;
    assign key = sad;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            err_stray_q <= 1'b0;
            min_key_q   <= '1;
            best_sad_q  <= '0;
            best_mvx_q  <= '0;
            best_mvy_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            err_stray_q <= sad_vld && (state_q != ST_SEARCH);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_SEARCH;
                        min_key_q <= '1;
                    end
                end
                ST_SEARCH: begin
                    if (sad_vld) begin
                        // Strict compare: on ties the earlier raster candidate stays the winner.
                        if (key < min_key_q) begin
                            min_key_q  <= key;
                            best_sad_q <= sad;
                            best_mvx_q <= cnt_x;
                            best_mvy_q <= cnt_y;
                        end
                        if (cnt_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == ST_SEARCH);
    assign done      = done_q;
    assign err_stray = err_stray_q;
    assign best_sad  = best_sad_q;
    assign best_mvx  = best_mvx_q;
    assign best_mvy  = best_mvy_q;
    assign cand_mvx  = cnt_x;
    assign cand_mvy  = cnt_y;

endmodule

// File: tb/tb_sad_min_search.sv
// Scoreboard bench for sad_min_search: RANGE=1 instance (random/directed) and a default RANGE=4 instance.
module tb_sad_min_search;

    localparam int NA = 9;
    localparam int NB = 81;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              a_start = 1'b0, a_vld = 1'b0;
    logic [15:0]       a_sad = '0;
    logic signed [2:0] a_cmx, a_cmy, a_bmx, a_bmy;
    logic              a_busy, a_done, a_err;
    logic [15:0]       a_bsad;

    logic              b_start = 1'b0, b_vld = 1'b0;
    logic [15:0]       b_sad = '0;
    logic signed [4:0] b_cmx, b_cmy, b_bmx, b_bmy;
    logic              b_busy, b_done, b_err;
    logic [15:0]       b_bsad;

    sad_min_search #(.DWIDTH(8), .RANGE(1), .MVW(3), .ZERO_BIAS(16)) dut_a (
        .clk(clk), .rstn(rstn), .start(a_start), .sad(a_sad), .sad_vld(a_vld),
        .cand_mvx(a_cmx), .cand_mvy(a_cmy), .busy(a_busy), .done(a_done),
        .best_sad(a_bsad), .best_mvx(a_bmx), .best_mvy(a_bmy), .err_stray(a_err));

    sad_min_search dut_b (
        .clk(clk), .rstn(rstn), .start(b_start), .sad(b_sad), .sad_vld(b_vld),
        .cand_mvx(b_cmx), .cand_mvy(b_cmy), .busy(b_busy), .done(b_done),
        .best_sad(b_bsad), .best_mvx(b_bmx), .best_mvy(b_bmy), .err_stray(b_err));

    typedef struct { int sad; int mx; int my; } res_t;
    res_t qa[$];
    res_t qb[$];
    res_t last_a;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: scan candidates in raster order and keep the first strictly smallest key.
    function automatic res_t ref_min(input int sads[$], input int range);
        int w;
        longint best_key;
        res_t r;
        w = 2 * range + 1;
        best_key = 64'd1 << 40;
        r = '{0, 0, 0};
        for (int i = 0; i < sads.size(); i++) begin
            int x, y;
            longint k;
            x = i % w - range;
            y = i / w - range;
            k = sads[i];
`ifdef SAD_MIN_ZERO_BIAS_EN
            if (x == 0 && y == 0) k = (k > 16) ? k - 16 : 0;
`endif
            if (k < best_key) begin
                best_key = k;
                r = '{sads[i], x, y};
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (a_done) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_done: got done=1 expected no result pending");
            end else begin
                e = qa.pop_front();
                chk("a_best_sad", a_bsad, e.sad);
                chk("a_best_mvx", $signed(a_bmx), e.mx);
                chk("a_best_mvy", $signed(a_bmy), e.my);
            end
        end
        if (b_done) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_done: got done=1 expected no result pending");
            end else begin
                e = qb.pop_front();
                chk("b_best_sad", b_bsad, e.sad);
                chk("b_best_mvx", $signed(b_bmx), e.mx);
                chk("b_best_mvy", $signed(b_bmy), e.my);
            end
        end
    end

    // One RANGE=1 search. gap_pct: idle-cycle probability; poke_at: index where start is re-asserted;
    // abort_after: index at which rstn is pulled instead of sending that candidate; stray_start: sad_vld with start.
    task automatic run_a(input int sads[$], input int gap_pct, input int poke_at,
                         input int abort_after, input bit stray_start);
        res_t e;
        e = ref_min(sads, 1);
        a_start = 1'b1;
        a_vld = stray_start;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_vld = 1'b0;
        chk("a_busy_on", a_busy, 1);
        chk("a_err_at_start", a_err, stray_start);
        for (int i = 0; i < NA; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk); #1;
            end
            chk("a_cand_x", $signed(a_cmx), i % 3 - 1);
            chk("a_cand_y", $signed(a_cmy), i / 3 - 1);
            if (i == abort_after) begin
                rstn = 1'b0;
                #1;
                chk("a_abort_busy", a_busy, 0);
                chk("a_abort_done", a_done, 0);
                chk("a_abort_best_sad", a_bsad, 0);
                chk("a_abort_best_mvx", $signed(a_bmx), 0);
                chk("a_abort_cand_x", $signed(a_cmx), -1);
                chk("a_abort_cand_y", $signed(a_cmy), -1);
                @(posedge clk); #1;
                rstn = 1'b1;
                @(posedge clk); #1;
                chk("a_abort_no_done", a_done, 0);
                return;
            end
            if (i == NA - 1) begin
                qa.push_back(e);
                last_a = e;
            end
            a_sad = 16'(sads[i]);
            a_vld = 1'b1;
            a_start = (i == poke_at);
            @(posedge clk); #1;
            a_vld = 1'b0;
            a_start = 1'b0;
        end
        chk("a_done_latency", a_done, 1);
        chk("a_busy_off", a_busy, 0);
        @(posedge clk); #1;
        chk("a_done_pulse", a_done, 0);
    endtask

    task automatic run_b(input int sads[$]);
        res_t e;
        e = ref_min(sads, 4);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk("b_cand_x", $signed(b_cmx), i % 9 - 4);
            chk("b_cand_y", $signed(b_cmy), i / 9 - 4);
            if (i == NB - 1) qb.push_back(e);
            b_sad = 16'(sads[i]);
            b_vld = 1'b1;
            @(posedge clk); #1;
            b_vld = 1'b0;
        end
        chk("b_done_latency", b_done, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s[$];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_best_sad", a_bsad, 0);
        chk("rst_best_mvx", $signed(a_bmx), 0);
        chk("rst_best_mvy", $signed(a_bmy), 0);
        chk("rst_cand_x", $signed(a_cmx), -1);
        chk("rst_cand_y", $signed(a_cmy), -1);
        chk("rst_b_cand_x", $signed(b_cmx), -4);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", a_busy, 0);
        chk("idle_done", a_done, 0);
        chk("idle_cand_y", $signed(a_cmy), -1);

        s = {50, 40, 60, 30, 70, 30, 90, 80, 35};
        run_a(s, 0, -1, -1, 1'b0);
        run_a(s, 40, -1, -1, 1'b0);

        a_vld = 1'b1;
        a_sad = 16'd1;
        @(posedge clk); #1;
        a_vld = 1'b0;
        chk("stray_err", a_err, 1);
        chk("stray_busy", a_busy, 0);
        @(posedge clk); #1;
        chk("stray_err_pulse", a_err, 0);
        chk("stray_best_sad", a_bsad, last_a.sad);
        chk("stray_best_mvx", $signed(a_bmx), last_a.mx);

        s = {};
        for (int i = 0; i < NA; i++) s.push_back($urandom_range(0, 20));
        run_a(s, 30, 3, -1, 1'b1);

        s = {};
        for (int i = 0; i < NA; i++) s.push_back($urandom_range(0, 500));
        run_a(s, 0, -1, 4, 1'b0);
        s = {};
        for (int i = 0; i < NA; i++) s.push_back($urandom_range(0, 500));
        run_a(s, 20, -1, -1, 1'b0);

        s = {100, 100, 100, 100, 110, 100, 100, 100, 95};
        run_a(s, 0, -1, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            s = {};
            for (int i = 0; i < NA; i++)
                s.push_back((r % 2 == 0) ? $urandom_range(0, 20) : $urandom_range(0, 65280));
            run_a(s, 25, -1, -1, 1'b0);
        end

        s = {};
        for (int i = 0; i < NB; i++) s.push_back($urandom_range(100, 5000));
        s[72] = 7;
        run_b(s);

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
